// File: rtl/data_inf_c_trigger_sink_if.sv
// Valid/ready stream interface used by the trigger path.
// A word transfers on a rising edge where valid && ready; data is meaningful only while valid is high.
interface data_inf_c #(
  parameter int DSIZE = 32
) (
  input logic clock,
  input logic rst_n
);
  logic             valid;
  logic             ready;
  logic [DSIZE-1:0] data;

  modport master (input clock, rst_n, ready, output valid, data);
  modport slave  (input clock, rst_n, valid, data, output ready);
endinterface

// File: rtl/data_inf_c_trigger_sink.sv
// Stream-to-event sink: buffers incoming words and replays each one as a single-cycle
// trigger pulse with its data on trig_data, enforcing a minimum low gap between pulses.
module data_inf_c_trigger_sink #(
  parameter int DSIZE = 32,
  parameter int DEPTH = 2,
  parameter int GAP   = 0
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       flush,
  data_inf_c.slave                   in_inf,
  output logic                       trigger,
  output logic [DSIZE-1:0]           trig_data,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic [1:0]                 state_dbg
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  if ($bits(in_inf.data) != DSIZE) begin : g_dsize_check
    $error("data_inf_c_trigger_sink: DSIZE does not match in_inf.DSIZE");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             trigger_q, trigger_d;
  logic [DSIZE-1:0] trig_data_q, trig_data_d;
  logic [DSIZE-1:0] mem_q [DEPTH];

  logic ready;
  logic push;
  logic pop;
  logic pop_slot;
  logic unused_inf;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (DEPTH == 1) return '0;
    else            return p + PW'(1);
  endfunction

  // Ready looks only at the registered count, never at a same-cycle pop.
  assign ready        = rst_n && enable && !flush && (count_q < DEPTH_C);
  assign in_inf.ready = ready;
  assign push         = in_inf.valid && ready;
  assign unused_inf   = &{1'b0, in_inf.clock, in_inf.rst_n};

  always_comb begin
    pop_slot = 1'b0;
    unique case (state_q)
      S_IDLE:  pop_slot = 1'b1;
      S_FIRE:  pop_slot = (GAP == 0);
      S_HOLD:  pop_slot = (gap_q == '0);
      default: pop_slot = 1'b0;
    endcase
  end

  assign pop = pop_slot && !flush && (count_q != '0);

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    trigger_d   = pop;
    trig_data_d = trig_data_q;
    count_d     = count_q + CW'(push) - CW'(pop);

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop) begin
      rd_ptr_d    = ptr_inc(rd_ptr_q);
      trig_data_d = mem_q[rd_ptr_q];
    end

    // The last HOLD cycle doubles as the IDLE-entry cycle so spacing is exactly GAP low cycles.
    unique case (state_q)
      S_IDLE: state_d = pop ? S_FIRE : S_IDLE;
      S_FIRE: begin
        if (pop) begin
          state_d = S_FIRE;
        end else if (GAP > 0) begin
          state_d = S_HOLD;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (gap_q == '0) state_d = pop ? S_FIRE : S_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d   = S_IDLE;
      gap_d     = '0;
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      trigger_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gap_q       <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      trigger_q   <= 1'b0;
      trig_data_q <= '0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      trigger_q   <= trigger_d;
      trig_data_q <= trig_data_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_inf.data;
  end

  assign trigger   = trigger_q;
  assign trig_data = trig_data_q;
  assign pending   = count_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_data_inf_c_trigger_sink.sv
// Bench for the trigger sink: two instances (GAP=0 and GAP=3) driven cycle by cycle and
// compared against a queue-and-timestamp reference model plus a directed vector table.
module tb_data_inf_c_trigger_sink;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int GAP_A = 0;
  localparam int GAP_B = 3;

  // clock / reset
  logic clock = 1'b0;
  logic rst_n;
  logic enable;
  logic flush;
  always #5 clock = ~clock;

  logic          v_in  [2];
  logic [DW-1:0] d_in  [2];
  logic [1:0]    trig;
  logic [DW-1:0] tdata [2];
  logic [1:0]    pend  [2];
  logic [1:0]    st    [2];
  logic [1:0]    rdy;
  logic [1:0]    acc;

  data_inf_c #(.DSIZE(DW)) if_a (.clock(clock), .rst_n(rst_n));
  data_inf_c #(.DSIZE(DW)) if_b (.clock(clock), .rst_n(rst_n));

  assign if_a.valid = v_in[0];
  assign if_a.data  = d_in[0];
  assign if_b.valid = v_in[1];
  assign if_b.data  = d_in[1];
  assign rdy        = {if_b.ready, if_a.ready};

  data_inf_c_trigger_sink #(.DSIZE(DW), .DEPTH(DEPTH), .GAP(GAP_A)) u_a (
    .clock(clock), .rst_n(rst_n), .enable(enable), .flush(flush), .in_inf(if_a.slave),
    .trigger(trig[0]), .trig_data(tdata[0]), .pending(pend[0]), .state_dbg(st[0])
  );

  data_inf_c_trigger_sink #(.DSIZE(DW), .DEPTH(DEPTH), .GAP(GAP_B)) u_b (
    .clock(clock), .rst_n(rst_n), .enable(enable), .flush(flush), .in_inf(if_b.slave),
    .trigger(trig[1]), .trig_data(tdata[1]), .pending(pend[1]), .state_dbg(st[1])
  );

  // scoreboard / reference model
  int            n_pass  = 0;
  int            n_total = 0;
  int            cyc     = 0;
  logic [DW-1:0] exp_q [2][$];
  int            last_fire [2];
  logic          exp_trig  [2];
  logic [DW-1:0] exp_data  [2];

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          en;
    logic          fl;
    logic          e_trig;
    logic [DW-1:0] e_data;
    logic [1:0]    e_pend;
    logic          e_rdy;
  } vec_t;
  vec_t tbl [6];

  function automatic int gap_of(input int k);
    return (k == 0) ? GAP_A : GAP_B;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      last_fire[k] = -1000;
      exp_trig[k]  = 1'b0;
      exp_data[k]  = '0;
    end
  endtask

  // One clock cycle: drive at the falling edge, check, then advance the model across the next rising edge.
  task automatic cycle(input logic v0, input logic [DW-1:0] d0, input logic v1,
                       input logic [DW-1:0] d1, input logic en, input logic fl);
    logic e_rdy;
    logic do_pop;
    @(negedge clock);
    v_in[0] = v0; d_in[0] = d0;
    v_in[1] = v1; d_in[1] = d1;
    enable  = en; flush   = fl;
    #1;
    for (int k = 0; k < 2; k++) begin
      e_rdy = rst_n && en && !fl && (exp_q[k].size() < DEPTH);
      chk($sformatf("u%0d trigger @%0d", k, cyc), DW'(trig[k]), DW'(exp_trig[k]));
      chk($sformatf("u%0d trig_data @%0d", k, cyc), tdata[k], exp_data[k]);
      chk($sformatf("u%0d pending @%0d", k, cyc), DW'(pend[k]), DW'(exp_q[k].size()));
      chk($sformatf("u%0d ready @%0d", k, cyc), DW'(rdy[k]), DW'(e_rdy));
      acc[k] = v_in[k] && rdy[k];
      do_pop = !fl && (exp_q[k].size() > 0) && (cyc >= last_fire[k] + gap_of(k));
      exp_trig[k] = 1'b0;
      if (fl) begin
        exp_q[k].delete();
        last_fire[k] = -1000;
      end else begin
        if (do_pop) begin
          exp_data[k]  = exp_q[k].pop_front();
          exp_trig[k]  = 1'b1;
          last_fire[k] = cyc + 1;
        end
        if (v_in[k] && e_rdy) exp_q[k].push_back(d_in[k]);
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    int nx [2];
    int fire_a [$];
    int fire_b [$];

    tbl[0] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         2'd0, 1'b1};
    tbl[1] = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 1'b0, 32'h0,         2'd0, 1'b1};
    tbl[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         2'd1, 1'b1};
    tbl[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 2'd0, 1'b1};
    tbl[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'hA5A5_0001, 2'd0, 1'b1};
    tbl[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'hA5A5_0001, 2'd0, 1'b1};

    // Reset: ready must stay low even with enable and valid high.
    rst_n  = 1'b0;
    enable = 1'b1;
    flush  = 1'b0;
    v_in[0] = 1'b1; d_in[0] = 32'h1234_5678;
    v_in[1] = 1'b1; d_in[1] = 32'h1234_5678;
    repeat (3) @(negedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d reset trigger", k), DW'(trig[k]), '0);
      chk($sformatf("u%0d reset trig_data", k), tdata[k], '0);
      chk($sformatf("u%0d reset pending", k), DW'(pend[k]), '0);
      chk($sformatf("u%0d reset ready", k), DW'(rdy[k]), '0);
      chk($sformatf("u%0d reset state", k), DW'(st[k]), '0);
    end
    v_in[0] = 1'b0; v_in[1] = 1'b0;
    model_reset();
    rst_n = 1'b1;

    // Directed single-word latency table.
    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].v, tbl[i].d, tbl[i].en, tbl[i].fl);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("tbl%0d u%0d trigger", i, k), DW'(trig[k]), DW'(tbl[i].e_trig));
        chk($sformatf("tbl%0d u%0d trig_data", i, k), tdata[k], tbl[i].e_data);
        chk($sformatf("tbl%0d u%0d pending", i, k), DW'(pend[k]), DW'(tbl[i].e_pend));
        chk($sformatf("tbl%0d u%0d ready", i, k), DW'(rdy[k]), DW'(tbl[i].e_rdy));
      end
    end

    // Continuous stream 1..8, each word held until accepted.
    nx[0] = 1; nx[1] = 1;
    for (int c = 0; c < 60; c++) begin
      cycle(nx[0] <= 8, DW'(nx[0]), nx[1] <= 8, DW'(nx[1]), 1'b1, 1'b0);
      if (trig[0]) fire_a.push_back(cyc);
      if (trig[1]) fire_b.push_back(cyc);
      for (int k = 0; k < 2; k++) if (acc[k]) nx[k]++;
    end
    chk("stream gap0 pulse count", DW'(fire_a.size()), DW'(8));
    if (fire_a.size() == 8)
      chk("stream gap0 back-to-back span", DW'(fire_a[7] - fire_a[0]), DW'(7));
    chk("stream gap3 pulse count", DW'(fire_b.size()), DW'(8));
    for (int i = 1; i < fire_b.size(); i++)
      chk($sformatf("stream gap3 spacing %0d", i), DW'(fire_b[i] - fire_b[i-1]), DW'(GAP_B + 1));

    // Enable low with valid held: nothing may be accepted or fired.
    for (int c = 0; c < 20; c++)
      cycle(1'b1, 32'hE000_0000 + DW'(c), 1'b1, 32'hE000_0000 + DW'(c), 1'b0, 1'b0);
    nx[0] = 0; nx[1] = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(nx[0] == 0, 32'hE0E0_0001, nx[1] == 0, 32'hE0E0_0001, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) if (acc[k]) nx[k]++;
    end

    // Fill the buffer, then flush: pending clears and trig_data is kept.
    nx[0] = 0; nx[1] = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, 32'hF000_0000 + DW'(nx[0]), 1'b1, 32'hF000_0000 + DW'(nx[1]), 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) if (acc[k]) nx[k]++;
    end
    chk("pre-flush u1 full", DW'(pend[1]), DW'(2));
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    idle(15);

    // Asynchronous reset while u_b sits in HOLD with one word buffered.
    cycle(1'b1, 32'h0000_0100, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
    cycle(1'b1, 32'h0000_0101, 1'b1, 32'h0000_0101, 1'b1, 1'b0);
    idle(2);
    chk("pre-reset u1 in hold", DW'(st[1]), DW'(2));
    chk("pre-reset u1 pending", DW'(pend[1]), DW'(1));
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("async reset u%0d trigger", k), DW'(trig[k]), '0);
      chk($sformatf("async reset u%0d pending", k), DW'(pend[k]), '0);
      chk($sformatf("async reset u%0d trig_data", k), tdata[k], '0);
    end
    model_reset();
    idle(2);
    rst_n = 1'b1;
    idle(10);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++)
      cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
            $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0);
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
